// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters (ALU, LSU) and the register-file
// write-port arbiter, including the write port and the forwarding/stall outputs.
interface regfile_wb_arbiter_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   logic             alu_valid_in;
   logic [4:0]       alu_rd_in;
   logic [XLEN-1:0]  alu_data_in;
   logic             alu_ready_out;
   logic             lsu_valid_in;
   logic [4:0]       lsu_rd_in;
   logic [XLEN-1:0]  lsu_data_in;
   logic             lsu_ready_out;
   logic             write_en;
   logic [4:0]       write_reg_num_out;
   logic [XLEN-1:0]  reg_write_out;
   logic             fwd_valid_out;
   logic [CNT_W-1:0] stall_cnt_out;

   modport master (
      output alu_valid_in, alu_rd_in, alu_data_in,
      output lsu_valid_in, lsu_rd_in, lsu_data_in,
      input  alu_ready_out, lsu_ready_out,
      input  write_en, write_reg_num_out, reg_write_out, fwd_valid_out, stall_cnt_out
   );

   modport slave (
      input  alu_valid_in, alu_rd_in, alu_data_in,
      input  lsu_valid_in, lsu_rd_in, lsu_data_in,
      output alu_ready_out, lsu_ready_out,
      output write_en, write_reg_num_out, reg_write_out, fwd_valid_out, stall_cnt_out
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU writeback,
// with a one-entry registered write stage and a saturating contention counter.
module regfile_wb_arbiter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic               clk_in,
   input logic               rst_n_in,
   regfile_wb_arbiter_if.slave wb
);

   typedef enum logic {PRIO_LSU = 1'b0, PRIO_ALU = 1'b1} prio_e;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

   prio_e            prio_q, prio_d;
   logic             wen_q, wen_d;
   logic [4:0]       addr_q, addr_d;
   logic [XLEN-1:0]  data_q, data_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic    grant_alu, grant_lsu, stalled;
   wb_req_t win;

   // Contention goes to the side named by prio; a lone requester always wins.
   always_comb begin
      grant_lsu = wb.lsu_valid_in && (!wb.alu_valid_in || (prio_q == PRIO_LSU));
      grant_alu = wb.alu_valid_in && (!wb.lsu_valid_in || (prio_q == PRIO_ALU));
      stalled   = (wb.alu_valid_in && !grant_alu) || (wb.lsu_valid_in && !grant_lsu);
      win       = grant_lsu ? wb_req_t'{rd: wb.lsu_rd_in, data: wb.lsu_data_in}
                            : wb_req_t'{rd: wb.alu_rd_in, data: wb.alu_data_in};
   end

   always_comb begin
      prio_d  = prio_q;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      stall_d = stall_q;
      if (grant_lsu) prio_d = PRIO_ALU;
      else if (grant_alu) prio_d = PRIO_LSU;
      if (grant_lsu || grant_alu) begin
         // x0 is hardwired zero: the request is consumed but never written.
         wen_d  = (win.rd != 5'd0);
         addr_d = win.rd;
         data_d = win.data;
      end
      if (stalled && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         prio_q  <= PRIO_LSU;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         stall_q <= '0;
      end else begin
         prio_q  <= prio_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         stall_q <= stall_d;
      end
   end

   assign wb.alu_ready_out     = grant_alu;
   assign wb.lsu_ready_out     = grant_lsu;
   assign wb.write_en          = wen_q;
   assign wb.fwd_valid_out     = wen_q;
   assign wb.write_reg_num_out = addr_q;
   assign wb.reg_write_out     = data_q;
   assign wb.stall_cnt_out     = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes into a scoreboard
// that an independent negedge monitor drains whenever the write port fires.
module tb_regfile_wb_arbiter;
   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [68:0] sb[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
   regfile_wb_arbiter_if #(.XLEN(XLEN), .CNT_W(4))  bus4 ();

   regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(16)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .wb(bus.slave));
   regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(4)) dut4 (
      .clk_in(clk), .rst_n_in(rst_n), .wb(bus4.slave));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write-port pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && (bus.write_en || bus.fwd_valid_out)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h expected none",
                     bus.write_reg_num_out, bus.reg_write_out);
         end else begin
            logic [68:0] e;
            e = sb.pop_front();
            chk("write_en", {63'd0, bus.write_en}, 64'd1);
            chk("fwd_valid", {63'd0, bus.fwd_valid_out}, 64'd1);
            chk("write_rd", {59'd0, bus.write_reg_num_out}, {59'd0, e[68:64]});
            chk("write_data", bus.reg_write_out, e[63:0]);
         end
      end
   end

   // One cycle of stimulus; entered and left at posedge+1.
   task automatic step(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                       input logic ea, input logic el);
      bus.alu_valid_in = av; bus.alu_rd_in = ar; bus.alu_data_in = ad;
      bus.lsu_valid_in = lv; bus.lsu_rd_in = lr; bus.lsu_data_in = ld;
      #1;
      chk("alu_ready", {63'd0, bus.alu_ready_out}, {63'd0, ea});
      chk("lsu_ready", {63'd0, bus.lsu_ready_out}, {63'd0, el});
      if (ea && ar != 5'd0) sb.push_back({ar, ad});
      if (el && lr != 5'd0) sb.push_back({lr, ld});
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.alu_valid_in = 0; bus.alu_rd_in = 0; bus.alu_data_in = 0;
      bus.lsu_valid_in = 0; bus.lsu_rd_in = 0; bus.lsu_data_in = 0;
      bus4.alu_valid_in = 0; bus4.alu_rd_in = 5'd1; bus4.alu_data_in = 64'h1;
      bus4.lsu_valid_in = 0; bus4.lsu_rd_in = 5'd2; bus4.lsu_data_in = 64'h2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_write_en", {63'd0, bus.write_en}, 64'd0);
      chk("rst_stall", {48'd0, bus.stall_cnt_out}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: LSU write to x5 in flight (prio now ALU), reset kills it.
      bus.lsu_valid_in = 1; bus.lsu_rd_in = 5'd5; bus.lsu_data_in = 64'h55;
      #1 chk("t1_lsu_ready", {63'd0, bus.lsu_ready_out}, 64'd1);
      @(posedge clk); #1;
      bus.lsu_valid_in = 0;
      rst_n = 1'b0;
      #1;
      chk("t1_write_en", {63'd0, bus.write_en}, 64'd0);
      chk("t1_fwd", {63'd0, bus.fwd_valid_out}, 64'd0);
      chk("t1_addr", {59'd0, bus.write_reg_num_out}, 64'd0);
      chk("t1_data", bus.reg_write_out, 64'd0);
      chk("t1_stall", {48'd0, bus.stall_cnt_out}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 3: contention from reset alternates LSU, ALU, LSU, ALU.
      step(1, 5'd1, 64'hA1, 1, 5'd2, 64'hB1, 0, 1);
      step(1, 5'd1, 64'hA1, 1, 5'd2, 64'hB2, 1, 0);
      step(1, 5'd1, 64'hA2, 1, 5'd2, 64'hB2, 0, 1);
      step(1, 5'd1, 64'hA2, 1, 5'd2, 64'hB3, 1, 0);
      step(0, 5'd0, 64'h0,  1, 5'd2, 64'hB3, 0, 1);
      chk("t3_stall", {48'd0, bus.stall_cnt_out}, 64'd4);
      step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0);

      // Test 2: ALU only.
      step(1, 5'd3, 64'hDEAD, 0, 5'd0, 64'h0, 1, 0);
      // Test 4: LSU to x0 is accepted but never written.
      step(0, 5'd0, 64'h0, 1, 5'd0, 64'hFFFF, 0, 1);
      chk("t4_write_en", {63'd0, bus.write_en}, 64'd0);
      chk("t4_fwd", {63'd0, bus.fwd_valid_out}, 64'd0);
      step(1, 5'd8, 64'h88, 1, 5'd9, 64'h99, 1, 0);
      step(0, 5'd0, 64'h0,  1, 5'd9, 64'h99, 0, 1);
      step(1, 5'd10, 64'hAA, 0, 5'd0, 64'h0, 1, 0);

      // Test 5: same rd from both, prio LSU: 0x11 then 0x22.
      step(1, 5'd7, 64'h22, 1, 5'd7, 64'h11, 0, 1);
      step(1, 5'd7, 64'h22, 0, 5'd0, 64'h0,  1, 0);
      step(0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  0, 0);
      chk("t5_idle_wen", {63'd0, bus.write_en}, 64'd0);
      chk("t5_hold_addr", {59'd0, bus.write_reg_num_out}, 64'd7);
      chk("t5_hold_data", bus.reg_write_out, 64'h22);
      chk("stall_total", {48'd0, bus.stall_cnt_out}, 64'd6);

      // Test 6: 4-bit counter saturates at 15 under constant contention.
      bus4.alu_valid_in = 1; bus4.lsu_valid_in = 1;
      repeat (10) @(posedge clk);
      #1 chk("t6_stall10", {60'd0, bus4.stall_cnt_out}, 64'd10);
      repeat (5) @(posedge clk);
      #1 chk("t6_stall15", {60'd0, bus4.stall_cnt_out}, 64'd15);
      repeat (5) @(posedge clk);
      #1 chk("t6_stall20", {60'd0, bus4.stall_cnt_out}, 64'd15);
      bus4.alu_valid_in = 0; bus4.lsu_valid_in = 0;

      repeat (2) @(posedge clk);
      #1 chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
